// File: rtl/counter_ctrl_if.sv
// Control/status bundle between counter_ctrl and its stimulus source and counter datapath.
// The controller connects through the slave modport; the driving side uses master.
interface counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             hold;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_en;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_din;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, stop, hold, auto_reload, load_val, term, cnt_q,
    input  cnt_en, cnt_load, cnt_din, busy, done, state
  );

  modport slave (
    input  start, stop, hold, auto_reload, load_val, term, cnt_q,
    output cnt_en, cnt_load, cnt_din, busy, done, state
  );
endinterface

// File: rtl/counter_ctrl.sv
// Sequencer for a WIDTH-bit up-counter: load, prescaled increment strobes, terminal
// count detection, then one-shot stop or auto-reload. Single clock, enable strobes only.
module counter_ctrl #(
   parameter int WIDTH = 4,
   parameter int DIV   = 4,
   parameter int PRE_W = 8
) (
   input logic          clk,
   input logic          reset,
   counter_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

   state_t           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [WIDTH-1:0] load_q, term_q;
   logic             reload_q;
   logic             accept, tick, at_term;
   logic             en, ld, dn;

   assign accept  = (state_q == IDLE) && bus.start && !bus.stop;
   assign tick    = (state_q == RUN) && !bus.hold && (pre_q == PRE_MAX);
   assign at_term = (bus.cnt_q == term_q);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
      state_d = state_q;
      pre_d   = '0;
      en      = 1'b0;
      ld      = 1'b0;
      dn      = 1'b0;
      unique case (state_q)
         IDLE: if (accept) state_d = LOAD;
         LOAD: begin
            state_d = bus.stop ? IDLE : RUN;
            ld      = !bus.stop;
         end
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else if (bus.hold) begin
               pre_d = pre_q;
            end else if (!tick) begin
               pre_d = pre_q + PRE_W'(1);
            end else if (!at_term) begin
               en = 1'b1;
            end else if (reload_q) begin
               // Reload in place: the counter dwelt one full period at term.
               ld = 1'b1;
               dn = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            dn      = !bus.stop;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state_q  <= IDLE;
         pre_q    <= '0;
         load_q   <= '0;
         term_q   <= '0;
         reload_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         if (accept) begin
            load_q   <= bus.load_val;
            term_q   <= bus.term;
            reload_q <= bus.auto_reload;
         end
      end
   end

   assign bus.cnt_en   = en;
   assign bus.cnt_load = ld;
   assign bus.done     = dn;
   assign bus.cnt_din  = load_q;
   assign bus.busy     = (state_q == LOAD) || (state_q == RUN);
   assign bus.state    = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: a schedule model predicts every strobe/done event
// and its cycle; a negedge monitor pops and compares each event the DUT presents.
module tb_counter_ctrl;
   localparam int WIDTH = 4;
   localparam int DIV   = 4;
   localparam int MOD   = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   counter_ctrl_if #(.WIDTH(WIDTH)) u_if ();
   counter_ctrl_if #(.WIDTH(WIDTH)) u_if1 ();

   counter_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .PRE_W(8)) dut (
      .clk(clk), .reset(reset), .bus(u_if.slave));
   counter_ctrl #(.WIDTH(WIDTH), .DIV(1), .PRE_W(8)) dut1 (
      .clk(clk), .reset(reset), .bus(u_if1.slave));

   // Counter datapaths driven by the strobes.
   logic [3:0] cnt  = 4'd0;
   logic [3:0] cnt1 = 4'd0;
   assign u_if.cnt_q  = cnt;
   assign u_if1.cnt_q = cnt1;
   always @(posedge clk) begin
      if (u_if.cnt_load)       cnt <= u_if.cnt_din;
      else if (u_if.cnt_en)    cnt <= cnt + 4'd1;
      if (u_if1.cnt_load)      cnt1 <= u_if1.cnt_din;
      else if (u_if1.cnt_en)   cnt1 <= cnt1 + 4'd1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Event kinds as {cnt_en, cnt_load, done}.
   localparam logic [2:0] EV_EN = 3'b100, EV_LD = 3'b010, EV_DN = 3'b001, EV_LDDN = 3'b011;

   typedef struct {
      int         cyc;
      logic [2:0] kind;
      logic [3:0] q;
      logic [3:0] din;
   } ev_t;

   ev_t exp_q[$];

   task automatic push_ev(input int c, input logic [2:0] k, input logic [3:0] q, input logic [3:0] d);
      ev_t e;
      e.cyc = c; e.kind = k; e.q = q; e.din = d;
      exp_q.push_back(e);
   endtask

   // Reference schedule: start seen in cycle t, load in t+1, RUN from t+2; every DIV-th
   // unheld RUN cycle is a tick. Events at or after stop_at are never produced.
   task automatic plan(input int t, input logic [3:0] lv, input logic [3:0] tv, input bit ar,
                       input int periods, input int h_from, input int h_len, input int stop_at,
                       output int last);
      int  steps, c, unheld, tk;
      bit  held;
      steps  = (int'(tv) - int'(lv) + MOD) % MOD;
      c      = t + 2;
      unheld = 0;
      last   = t + 1;
      if (t + 1 >= stop_at) return;
      push_ev(t + 1, EV_LD, 4'd0, lv);
      for (int p = 0; p < periods; p++) begin
         for (int j = 0; j <= steps; j++) begin
            while (1) begin
               held = (c >= h_from) && (c < h_from + h_len);
               c++;
               if (!held) begin
                  unheld++;
                  if (unheld == DIV) break;
               end
            end
            unheld = 0;
            tk     = c - 1;
            if (tk >= stop_at) return;
            if (j < steps) begin
               push_ev(tk, EV_EN, 4'((int'(lv) + j) % MOD), lv);
            end else if (ar) begin
               push_ev(tk, EV_LDDN, tv, lv);
            end else begin
               if (tk + 1 < stop_at) push_ev(tk + 1, EV_DN, tv, lv);
               last = tk + 1;
               return;
            end
            last = tk;
         end
      end
   endtask

   // Monitor: every presented event must match the head of the scoreboard.
   logic [2:0] mon_k;
   ev_t        mon_e;
   always @(negedge clk) begin
      if (!reset) begin
         check("en_load_exclusive", 32'(u_if.cnt_en & u_if.cnt_load), 32'd0);
         mon_k = {u_if.cnt_en, u_if.cnt_load, u_if.done};
         if (mon_k != 3'b000) begin
            if (exp_q.size() == 0) begin
               check("unexpected_event", 32'(mon_k), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("ev_cycle", 32'(cyc), 32'(mon_e.cyc));
               check("ev_kind", 32'(mon_k), 32'(mon_e.kind));
               if (mon_e.kind != EV_LD) check("ev_cnt_q", 32'(cnt), 32'(mon_e.q));
               if (mon_k[1]) check("ev_cnt_din", 32'(u_if.cnt_din), 32'(mon_e.din));
            end
         end
      end
   end

   // One transaction; offsets are relative to the start cycle, negative means unused.
   task automatic txn(input logic [3:0] lv, input logic [3:0] tv, input bit ar, input int periods,
                      input int h_off, input int h_len, input int stop_off, input int bstart_off);
      int t, last, stop_c, end_c;
      t      = cyc;
      stop_c = (stop_off >= 0) ? t + stop_off : 32'h3fff_ffff;
      plan(t, lv, tv, ar, periods, t + h_off, h_len, stop_c, last);
      if (stop_off < 0 && ar) stop_c = last + 1;
      end_c = (stop_off >= 0 || ar) ? stop_c : last;
      for (int c = t; c <= end_c + 2; c++) begin
         if (c == t) begin
            u_if.load_val    = lv;
            u_if.term        = tv;
            u_if.auto_reload = ar;
         end else begin
            u_if.load_val    = 4'($urandom);
            u_if.term        = 4'($urandom);
            u_if.auto_reload = 1'($urandom);
         end
         u_if.start = (c == t) || (bstart_off >= 0 && c == t + bstart_off);
         u_if.hold  = (c >= t + h_off) && (c < t + h_off + h_len);
         u_if.stop  = (c == stop_c);
         @(posedge clk); #1;
      end
      u_if.start = 1'b0;
      u_if.stop  = 1'b0;
      u_if.hold  = 1'b0;
      check("idle_after_txn", 32'(u_if.state), 32'd0);
      check("busy_after_txn", 32'(u_if.busy), 32'd0);
      if (!ar && stop_off < 0) check("final_cnt_q", 32'(cnt), 32'(tv));
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic tick_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, last;
      u_if.start = 1'b0;  u_if.stop = 1'b0;  u_if.hold = 1'b0;  u_if.auto_reload = 1'b0;
      u_if.load_val = 4'd0; u_if.term = 4'd0;
      u_if1.start = 1'b0; u_if1.stop = 1'b0; u_if1.hold = 1'b0; u_if1.auto_reload = 1'b0;
      u_if1.load_val = 4'd0; u_if1.term = 4'd0;

      // Reset state
      tick_cycles(3);
      check("rst_state", 32'(u_if.state), 32'd0);
      check("rst_busy", 32'(u_if.busy), 32'd0);
      check("rst_done", 32'(u_if.done), 32'd0);
      check("rst_cnt_en", 32'(u_if.cnt_en), 32'd0);
      check("rst_cnt_load", 32'(u_if.cnt_load), 32'd0);
      check("rst_cnt_din", 32'(u_if.cnt_din), 32'd0);
      reset = 1'b0;
      tick_cycles(2);

      // One-shot, auto-reload, hold, busy start, stop in RUN, load==term
      txn(4'd3,  4'd6, 1'b0, 1, 0, 0,  -1, -1);
      txn(4'd14, 4'd1, 1'b1, 2, 0, 0,  -1, -1);
      txn(4'd0,  4'd2, 1'b0, 1, 4, 10, -1, -1);
      txn(4'd3,  4'd6, 1'b0, 1, 0, 0,  -1, 5);
      txn(4'd0,  4'd5, 1'b0, 1, 0, 0,  9,  -1);
      txn(4'd9,  4'd9, 1'b0, 1, 0, 0,  -1, -1);

      // start and stop together in IDLE
      u_if.start = 1'b1; u_if.stop = 1'b1; u_if.load_val = 4'd7; u_if.term = 4'd8;
      tick_cycles(1);
      u_if.start = 1'b0; u_if.stop = 1'b0;
      check("start_stop_state", 32'(u_if.state), 32'd0);
      tick_cycles(3);
      check("start_stop_busy", 32'(u_if.busy), 32'd0);

      // Reset asserted mid-RUN (not on a tick cycle)
      t = cyc;
      plan(t, 4'd2, 4'd10, 1'b0, 1, 0, 0, t + 4, last);
      u_if.start = 1'b1; u_if.load_val = 4'd2; u_if.term = 4'd10; u_if.auto_reload = 1'b0;
      tick_cycles(1);
      u_if.start = 1'b0;
      tick_cycles(3);
      check("pre_reset_state", 32'(u_if.state), 32'd2);
      reset = 1'b1;
      tick_cycles(1);
      reset = 1'b0;
      check("midrst_state", 32'(u_if.state), 32'd0);
      check("midrst_busy", 32'(u_if.busy), 32'd0);
      check("midrst_done", 32'(u_if.done), 32'd0);
      check("midrst_cnt_en", 32'(u_if.cnt_en), 32'd0);
      check("midrst_cnt_load", 32'(u_if.cnt_load), 32'd0);
      check("midrst_cnt_din", 32'(u_if.cnt_din), 32'd0);
      check("midrst_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      tick_cycles(2);

      // Randomized transactions
      for (int i = 0; i < 12; i++) begin
         int per, hoff, hlen, soff, boff;
         logic [3:0] lv, tv;
         bit ar;
         lv   = 4'($urandom);
         tv   = 4'($urandom);
         ar   = 1'($urandom);
         per  = ar ? int'($urandom_range(1, 2)) : 1;
         hoff = int'($urandom_range(1, 12));
         hlen = int'($urandom_range(0, 6));
         soff = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 20)) : -1;
         boff = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 2)) : -1;
         txn(lv, tv, ar, per, hoff, hlen, soff, boff);
         tick_cycles(int'($urandom_range(0, 3)));
      end

      // DIV=1 instance: 0 -> 3 one-shot
      u_if1.start = 1'b1; u_if1.load_val = 4'd0; u_if1.term = 4'd3; u_if1.auto_reload = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick_cycles(1);
         u_if1.start = 1'b0;
         check("d1_cnt_load", 32'(u_if1.cnt_load), 32'(k == 1));
         check("d1_cnt_en", 32'(u_if1.cnt_en), 32'(k >= 2 && k <= 4));
         check("d1_done", 32'(u_if1.done), 32'(k == 6));
         check("d1_state", 32'(u_if1.state),
               (k == 1) ? 32'd1 : (k <= 5) ? 32'd2 : (k == 6) ? 32'd3 : 32'd0);
      end
      check("d1_final_cnt", 32'(cnt1), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
